// File: rtl/pool_layer_v2.sv
// Streaming MAX/AVG pooling over a channel-planar blob with optional ReLU,
// frame-error detection and a first-word-fall-through output FIFO.
module pool_layer_v2 #(
    parameter int DW       = 16,
    parameter int W_IN     = 8,
    parameter int H_IN     = 8,
    parameter int C_IN     = 8,
    parameter int WIN_LOG2 = 1,
    parameter int MODE     = 0,
    parameter int RELU     = 0,
    parameter int FIFO_AW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          blob_din_rdy,
    input  logic          blob_din_en,
    input  logic          blob_din_eop,
    input  logic [DW-1:0] blob_din,
    input  logic          blob_dout_rdy,
    output logic          blob_dout_en,
    output logic          blob_dout_eop,
    output logic [DW-1:0] blob_dout,
    output logic          frame_err
);

    localparam int K     = 1 << WIN_LOG2;
    localparam int W_OUT = W_IN / K;
    localparam int H_OUT = H_IN / K;
    localparam int ACC_W = DW + 2 * WIN_LOG2;
    localparam int XW    = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int YW    = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam int CW    = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam int AIW   = (W_OUT > 1) ? $clog2(W_OUT) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [XW-1:0]       X_LAST      = XW'(W_IN - 1);
    localparam logic [YW-1:0]       Y_LAST      = YW'(H_IN - 1);
    localparam logic [CW-1:0]       C_LAST      = CW'(C_IN - 1);
    localparam logic [XW-1:0]       X_GRID_LAST = XW'(W_OUT * K - 1);
    localparam logic [YW-1:0]       Y_GRID_LAST = YW'(H_OUT * K - 1);
    localparam logic [XW-1:0]       OX_LAST     = XW'(W_OUT - 1);
    localparam logic [YW-1:0]       OY_LAST     = YW'(H_OUT - 1);
    localparam logic [WIN_LOG2-1:0] SUB_LAST    = '1;
    localparam logic [FIFO_AW:0]    CNT_RDY_MAX = (FIFO_AW + 1)'(DEPTH - 2);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_c;
    logic          r_run;
    logic          r_frame_err;

    logic                    w_accept;
    logic                    w_pos_last;
    logic [XW-1:0]           w_ox;
    logic [YW-1:0]           w_oy;
    logic [WIN_LOG2-1:0]     w_xm;
    logic [WIN_LOG2-1:0]     w_ym;
    logic                    w_in_grid;
    logic                    w_first;
    logic                    w_done;
    logic                    w_last_win;
    logic [AIW-1:0]          w_idx;
    logic signed [ACC_W-1:0] w_din_ext;
    logic signed [ACC_W-1:0] w_acc_cur;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_res;
    logic                    w_unused;

    logic signed [ACC_W-1:0] r_acc [W_OUT];
    logic                    r_p_vld;
    logic                    r_p_eop;
    logic [DW-1:0]           r_p_data;

    logic [DW:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_cnt;
    logic [DW-1:0]      r_last;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [DW:0]        w_head;

    assign w_accept   = blob_din_en & blob_din_rdy;
    assign w_pos_last = (r_x == X_LAST) && (r_y == Y_LAST) && (r_c == C_LAST);
    assign w_ox       = r_x >> WIN_LOG2;
    assign w_oy       = r_y >> WIN_LOG2;
    assign w_xm       = r_x[WIN_LOG2-1:0];
    assign w_ym       = r_y[WIN_LOG2-1:0];
    assign w_in_grid  = (r_x <= X_GRID_LAST) && (r_y <= Y_GRID_LAST);
    assign w_first    = (w_xm == '0) && (w_ym == '0);
    assign w_done     = w_in_grid && (w_xm == SUB_LAST) && (w_ym == SUB_LAST);
    assign w_last_win = (r_c == C_LAST) && (w_oy == OY_LAST) && (w_ox == OX_LAST);
    assign w_idx      = w_ox[AIW-1:0];
    assign w_din_ext  = ACC_W'($signed(blob_din));
    assign w_acc_cur  = r_acc[w_idx];
    assign w_unused   = ^w_res;

    always_comb begin
        w_acc_next = w_din_ext;
        if (!w_first) begin
            if (MODE == 0) begin
                w_acc_next = (w_din_ext > w_acc_cur) ? w_din_ext : w_acc_cur;
            end else begin
                w_acc_next = w_acc_cur + w_din_ext;
            end
        end
        w_res = (MODE == 0) ? w_acc_next : (w_acc_next >>> (2 * WIN_LOG2));
        if ((RELU != 0) && w_res[ACC_W-1]) begin
            w_res = '0;
        end
    end

    // An eop anywhere but the final position restarts the frame; the next
    // frame's first beat per window overwrites any stale partial accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_c         <= '0;
            r_run       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                if (blob_din_eop) begin
                    r_x <= '0;
                    r_y <= '0;
                    r_c <= '0;
                    if (!w_pos_last) begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    if (w_pos_last) begin
                        r_frame_err <= 1'b1;
                    end
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        if (r_y == Y_LAST) begin
                            r_y <= '0;
                            r_c <= (r_c == C_LAST) ? '0 : r_c + 1'b1;
                        end else begin
                            r_y <= r_y + 1'b1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_in_grid) begin
            r_acc[w_idx] <= w_acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_vld  <= 1'b0;
            r_p_eop  <= 1'b0;
            r_p_data <= '0;
        end else begin
            r_p_vld <= w_accept && w_done;
            if (w_accept && w_done) begin
                r_p_data <= w_res[DW-1:0];
                r_p_eop  <= w_last_win;
            end
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_push  = r_p_vld;
    assign w_pop   = blob_dout_rdy & ~w_empty;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_p_eop, r_p_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_last <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_last <= w_head[DW-1:0];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // One free slot stays reserved for the result already in the pipeline.
    assign blob_din_rdy  = r_run && (r_cnt <= CNT_RDY_MAX);
    assign blob_dout_en  = w_pop;
    assign blob_dout_eop = w_pop & w_head[DW];
    assign blob_dout     = w_empty ? r_last : w_head[DW-1:0];
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_pool_layer_v2.sv
// Directed bench: three 4x4x1 instances (MAX, AVG, ReLU-MAX) share one input
// stream; a default-parameter instance runs a full 8x8x8 frame under backpressure.
module tb_pool_layer_v2;

    localparam int DW = 16;

    typedef struct packed {
        logic               e;
        logic signed [31:0] d;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_en, s_eop, s_ordy;
    logic [DW-1:0] s_din;
    logic          rdy_m, en_m, eop_m, err_m;
    logic          rdy_a, en_a, eop_a, err_a;
    logic          rdy_r, en_r, eop_r, err_r;
    logic [DW-1:0] dout_m, dout_a, dout_r;

    logic          d_en, d_eop, d_ordy;
    logic [DW-1:0] d_din;
    logic          rdy_d, en_d, eop_d, err_d;
    logic [DW-1:0] dout_d;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t qm[$], qa[$], qr[$], qd[$];
    logic stall = 1'b0;
    logic rdy_low_seen = 1'b0;

    pool_layer_v2 #(.DW(DW), .W_IN(4), .H_IN(4), .C_IN(1), .WIN_LOG2(1),
                    .MODE(0), .RELU(0), .FIFO_AW(2)) u_max (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy_m), .blob_din_en(s_en),
        .blob_din_eop(s_eop), .blob_din(s_din), .blob_dout_rdy(s_ordy),
        .blob_dout_en(en_m), .blob_dout_eop(eop_m), .blob_dout(dout_m),
        .frame_err(err_m));

    pool_layer_v2 #(.DW(DW), .W_IN(4), .H_IN(4), .C_IN(1), .WIN_LOG2(1),
                    .MODE(1), .RELU(0), .FIFO_AW(2)) u_avg (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy_a), .blob_din_en(s_en),
        .blob_din_eop(s_eop), .blob_din(s_din), .blob_dout_rdy(s_ordy),
        .blob_dout_en(en_a), .blob_dout_eop(eop_a), .blob_dout(dout_a),
        .frame_err(err_a));

    pool_layer_v2 #(.DW(DW), .W_IN(4), .H_IN(4), .C_IN(1), .WIN_LOG2(1),
                    .MODE(0), .RELU(1), .FIFO_AW(2)) u_relu (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy_r), .blob_din_en(s_en),
        .blob_din_eop(s_eop), .blob_din(s_din), .blob_dout_rdy(s_ordy),
        .blob_dout_en(en_r), .blob_dout_eop(eop_r), .blob_dout(dout_r),
        .frame_err(err_r));

    pool_layer_v2 u_def (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy_d), .blob_din_en(d_en),
        .blob_din_eop(d_eop), .blob_din(d_din), .blob_dout_rdy(d_ordy),
        .blob_dout_en(en_d), .blob_dout_eop(eop_d), .blob_dout(dout_d),
        .frame_err(err_d));

    function automatic out_t mk(input logic e, input logic [DW-1:0] v);
        out_t o;
        o.e = e;
        o.d = 32'($signed(v));
        return o;
    endfunction

    always @(negedge clk) begin
        if (en_m) qm.push_back(mk(eop_m, dout_m));
        if (en_a) qa.push_back(mk(eop_a, dout_a));
        if (en_r) qr.push_back(mk(eop_r, dout_r));
        if (en_d) qd.push_back(mk(eop_d, dout_d));
        if (stall && !rdy_d) rdy_low_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        qm.delete(); qa.delete(); qr.delete(); qd.delete();
    endtask

    task automatic beat_s(input int d, input logic e);
        int n = 0;
        s_din = DW'(d);
        s_eop = e;
        s_en  = 1'b1;
        while (!(rdy_m && rdy_a && rdy_r) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_eq("s_rdy_wait", int'(rdy_m && rdy_a && rdy_r), 1);
        @(posedge clk); #1;
    endtask

    // kind 0: ramp, 1: negated ramp, 2: all -100 except 7 at (1,1)
    task automatic frame_s(input int kind, input int last, input logic with_eop);
        int v;
        for (int i = 0; i <= last; i++) begin
            case (kind)
                0:       v = i;
                1:       v = -i;
                default: v = (i == 5) ? 7 : -100;
            endcase
            beat_s(v, with_eop && (i == last));
        end
        s_en  = 1'b0;
        s_eop = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string tag, input out_t q[$], input int e0,
                           input int e1, input int e2, input int e3,
                           input int n, input logic eop_last);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        check_eq({tag, "_cnt"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            check_eq($sformatf("%s_d%0d", tag, i), int'(q[i].d), ex[i]);
            check_eq($sformatf("%s_e%0d", tag, i), int'(q[i].e),
                     int'(eop_last && (i == n - 1)));
        end
    endtask

    task automatic run_default();
        int din_d[512];
        int exp_d[128];
        int m, v, n, n_eop;
        for (int i = 0; i < 512; i++) din_d[i] = int'($urandom_range(0, 4000)) - 2000;
        for (int c = 0; c < 8; c++)
            for (int oy = 0; oy < 4; oy++)
                for (int ox = 0; ox < 4; ox++) begin
                    m = din_d[c*64 + (2*oy)*8 + 2*ox];
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = din_d[c*64 + (2*oy+dy)*8 + 2*ox + dx];
                            if (v > m) m = v;
                        end
                    exp_d[c*16 + oy*4 + ox] = m;
                end
        clear_q();
        fork
            begin
                for (int i = 0; i < 512; i++) begin
                    int w = 0;
                    d_din = DW'(din_d[i]);
                    d_eop = (i == 511);
                    d_en  = 1'b1;
                    while (!rdy_d && w < 1000) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 1000) check_eq("d_rdy_wait", int'(rdy_d), 1);
                    @(posedge clk); #1;
                end
                d_en  = 1'b0;
                d_eop = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 600; cyc++) begin
                    if (cyc >= 250 && cyc < 300) begin
                        stall  = 1'b1;
                        d_ordy = 1'b0;
                    end else begin
                        stall  = 1'b0;
                        d_ordy = 1'($urandom_range(0, 1));
                    end
                    @(posedge clk); #1;
                end
                stall  = 1'b0;
                d_ordy = 1'b1;
            end
        join
        n = 0;
        while (qd.size() < 128 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq("def_cnt", qd.size(), 128);
        n_eop = 0;
        for (int i = 0; i < 128 && i < qd.size(); i++) begin
            check_eq($sformatf("def_d%0d", i), int'(qd[i].d), exp_d[i]);
            if (qd[i].e) n_eop++;
        end
        check_eq("def_eop_cnt", n_eop, 1);
        if (qd.size() >= 128) check_eq("def_eop_last", int'(qd[127].e), 1);
        check_eq("def_rdy_low", int'(rdy_low_seen), 1);
        check_eq("def_err", int'(err_d), 0);
    endtask

    initial begin
        s_en = 1'b0; s_eop = 1'b0; s_din = '0; s_ordy = 1'b1;
        d_en = 1'b0; d_eop = 1'b0; d_din = '0; d_ordy = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdy", int'(rdy_m), 0);
        check_eq("rst_en", int'(en_m), 0);
        check_eq("rst_eop", int'(eop_m), 0);
        check_eq("rst_dout", int'(dout_m), 0);
        check_eq("rst_err", int'(err_m), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("run_rdy", int'(rdy_m), 1);

        clear_q();
        frame_s(0, 15, 1'b1);
        check_q("max_ramp", qm, 5, 7, 13, 15, 4, 1'b1);
        check_q("avg_ramp", qa, 2, 4, 10, 12, 4, 1'b1);
        check_q("relu_ramp", qr, 5, 7, 13, 15, 4, 1'b1);
        check_eq("ramp_err", int'(err_m), 0);

        clear_q();
        frame_s(1, 15, 1'b1);
        check_q("max_neg", qm, 0, -2, -8, -10, 4, 1'b1);
        check_q("avg_neg", qa, -3, -5, -11, -13, 4, 1'b1);
        check_q("relu_neg", qr, 0, 0, 0, 0, 4, 1'b1);

        clear_q();
        frame_s(2, 15, 1'b1);
        check_q("relu_pat", qr, 7, 0, 0, 0, 4, 1'b1);
        check_q("max_pat", qm, 7, -100, -100, -100, 4, 1'b1);
        check_q("avg_pat", qa, -74, -100, -100, -100, 4, 1'b1);
        check_eq("pat_err", int'(err_r), 0);

        clear_q();
        frame_s(0, 10, 1'b1);
        check_q("early", qm, 5, 7, 0, 0, 2, 1'b0);
        check_eq("early_err", int'(err_m), 1);
        clear_q();
        frame_s(0, 15, 1'b1);
        check_q("after_early", qm, 5, 7, 13, 15, 4, 1'b1);
        check_eq("err_sticky", int'(err_m), 1);

        clear_q();
        s_ordy = 1'b0;
        frame_s(0, 13, 1'b0);
        check_eq("fifo3_rdy", int'(rdy_m), 0);
        check_eq("fifo3_noout", qm.size(), 0);
        rst    = 1'b0;
        s_ordy = 1'b1;
        #1;
        check_eq("mid_rst_en", int'(en_m), 0);
        check_eq("mid_rst_rdy", int'(rdy_m), 0);
        check_eq("mid_rst_dout", int'(dout_m), 0);
        check_eq("mid_rst_err", int'(err_m), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_q();
        frame_s(0, 15, 1'b1);
        check_q("post_rst", qm, 5, 7, 13, 15, 4, 1'b1);
        check_eq("post_rst_err", int'(err_m), 0);

        clear_q();
        frame_s(0, 15, 1'b0);
        check_q("no_eop", qm, 5, 7, 13, 15, 4, 1'b1);
        check_eq("no_eop_err", int'(err_m), 1);

        run_default();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
